// File: rtl/led_arb_pkg.sv
// Shared types and sizes for the LED bank arbiter.
// Four pattern sources compete for one 8-bit LED bank.
package led_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every DIV enabled cycles.
// Dropping en_i clears the count so the next enabled run starts from zero.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == CntMax);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of an LED bank: a grant lasts SLOT_TICKS ticks or until the
// owner drops its request, followed by one blank GAP cycle and one IDLE cycle.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned SLOT_TICKS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [LED_W-1:0]   i_pat0,
    input  logic [LED_W-1:0]   i_pat1,
    input  logic [LED_W-1:0]   i_pat2,
    input  logic [LED_W-1:0]   i_pat3,
    output logic [LED_W-1:0]   o_led,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_busy
);

    localparam int unsigned SlotW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [SlotW-1:0] SlotMax = SlotW'(SLOT_TICKS - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SlotW-1:0]   slot_q, slot_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [LED_W-1:0]   pat [NUM_REQ];
    logic               own_req;
    logic               run_en;
    logic               tick;
    logic               slot_last;

    assign pat[0] = i_pat0;
    assign pat[1] = i_pat1;
    assign pat[2] = i_pat2;
    assign pat[3] = i_pat3;

    // First requester at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Counters run only while the owner keeps requesting, so both read 0 outside GRANT.
    assign own_req   = i_req[idx_q];
    assign run_en    = (state_q == StGrant) && own_req;
    assign slot_last = tick && (slot_q == SlotMax);

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .en_i   (run_en),
        .tick_o (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        slot_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (|i_req) begin
                    state_d = StGrant;
                    idx_d   = rr_pick(i_req, ptr_q);
                end
            end
            StGrant: begin
                if (!own_req || slot_last) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
                ptr_d   = idx_q + IDX_W'(1);
            end
            default: state_d = StIdle;
        endcase
        if (run_en) begin
            slot_d = slot_q;
            if (tick) begin
                slot_d = (slot_q == SlotMax) ? '0 : slot_q + SlotW'(1);
            end
        end
    end

    // Outputs are computed from the next state so the registers line up with it.
    always_comb begin
        led_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        if (state_d == StGrant) begin
            led_d   = pat[idx_d];
            grant_d = idx_to_onehot(idx_d);
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            led_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign o_led   = led_q;
    assign o_grant = grant_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: a slot-level reference model predicts every
// registered output, a monitor compares DUT outputs against the queued predictions.
module tb_led_arbiter;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned SLOT_TICKS = 2;
    localparam int          SLOT_CYC   = TICK_DIV * SLOT_TICKS;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] led;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] pat0, pat1, pat2, pat3;
    logic [7:0] led;
    logic [3:0] grant;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];

    // Reference model: who owns the bank, for how many cycles, and how many
    // blank cycles remain before requests are looked at again.
    int m_owner = -1;
    int m_served = 0;
    int m_cool = 0;
    int m_ptr = 0;

    led_arbiter #(
        .TICK_DIV   (TICK_DIV),
        .SLOT_TICKS (SLOT_TICKS)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_pat0  (pat0),
        .i_pat1  (pat1),
        .i_pat2  (pat2),
        .i_pat3  (pat3),
        .o_led   (led),
        .o_grant (grant),
        .o_busy  (busy)
    );

    always #10 clk = ~clk;

    task automatic report(input string name, input exp_t got, input exp_t want);
        n_fail++;
        if (n_fail <= 30) begin
            $display("FAIL %s @%0t: got grant=%b led=%h busy=%b, expected grant=%b led=%h busy=%b",
                     name, $time, got.grant, got.led, got.busy, want.grant, want.led, want.busy);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, queue the prediction.
    task automatic step(input logic r, input logic [3:0] q,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        logic [7:0] pm [4];
        exp_t       e;
        exp_t       now;
        bit         found;
        @(negedge clk);
        #2;
        rst  = r;
        req  = q;
        pat0 = a;
        pat1 = b;
        pat2 = c;
        pat3 = d;
        pm[0] = a;
        pm[1] = b;
        pm[2] = c;
        pm[3] = d;
        if (r) begin
            m_owner  = -1;
            m_served = 0;
            m_cool   = 0;
            m_ptr    = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || m_served == SLOT_CYC) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_served++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (q != 4'b0000) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && q[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    found   = 1'b1;
                end
            end
            m_served = 1;
        end
        e = '0;
        if (m_owner >= 0) begin
            e.grant = 4'b0001 << m_owner;
            e.led   = pm[m_owner];
            e.busy  = 1'b1;
        end
        sb.push_back(e);
        if (r) begin
            // Reset is asynchronous: outputs must already be clear before any edge.
            #1;
            now = '{grant: grant, led: led, busy: busy};
            n_tests++;
            if (now != '0) report("async_reset_clear", now, '0);
        end
    endtask

    // Monitor: every output cycle is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t want;
        exp_t got;
        if (sb.size() != 0) begin
            want = sb.pop_front();
            got  = '{grant: grant, led: led, busy: busy};
            n_tests++;
            if (got !== want) report("outputs", got, want);
        end
    end

    initial begin
        logic [3:0] req_v;
        bit         hit;
        exp_t       none;
        none = '0;
        rst  = 1'b1;
        req  = 4'b1111;
        pat0 = 8'h00;
        pat1 = 8'h00;
        pat2 = 8'h00;
        pat3 = 8'h00;

        // Held reset with every source requesting.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Sole persistent requester.
        for (int i = 0; i < 25; i++) step(1'b0, 4'b0001, 8'hA5, 8'h11, 8'h22, 8'h33);

        // All sources requesting with distinct patterns.
        for (int i = 0; i < 45; i++) step(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);

        // Owner source 1 drops its request on the third cycle of its slot.
        req_v = 4'b1111;
        hit   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (!hit && m_owner == 1 && m_served == 3) begin
                req_v[1] = 1'b0;
                hit      = 1'b1;
            end
            step(1'b0, req_v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        n_tests++;
        if (!hit) report("early_drop_reached", none, '{grant: 4'b0010, led: 8'h00, busy: 1'b1});

        // Reset pulse on the fourth cycle of source 2's slot.
        hit = 1'b0;
        for (int c = 0; c < 80 && !hit; c++) begin
            if (m_owner == 2 && m_served == 4) begin
                step(1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
                hit = 1'b1;
            end else begin
                step(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
            end
        end
        n_tests++;
        if (!hit) report("mid_slot_reset_reached", none, '{grant: 4'b0100, led: 8'h33, busy: 1'b1});
        for (int i = 0; i < 15; i++) step(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);

        // Sources 1 and 3 only: pointer must wrap past 3 back to source 1.
        step(1'b1, 4'b1010, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 40; i++) step(1'b0, 4'b1010, 8'h5A, 8'hC3, 8'h0F, 8'hF0);

        // Random traffic with changing patterns and occasional resets.
        req_v = 4'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) req_v = 4'($urandom);
            step(($urandom_range(199) == 0), req_v,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, is the clock cycles per tick (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 Parameter SLOT_TICKS, default 4, is the ticks per grant slot; legal range is 1 or more.
REQ-003 Port i_clk SHALL be an input, 1 bit wide: the single system clock, rising edge.
REQ-004 Port i_rst SHALL be an input, 1 bit wide: reset, asynchronous, active-high.
REQ-005 Port i_req SHALL be an input, 4 bits wide: request per pattern source (switch bank), level-sensitive.
REQ-006 Ports i_pat0..i_pat3 SHALL be inputs, 8 bits each: LED pattern offered by source 0..3.
REQ-007 Port o_led SHALL be an output, 8 bits wide: LED bank drive.
REQ-008 Port o_grant SHALL be an output, 4 bits wide: one-hot owner of the LED bank, 0 when unowned.
REQ-009 Port o_busy SHALL be an output, 1 bit wide: high while in GRANT.

Function
REQ-010 The controller SHALL have three states: IDLE, GRANT and GAP.
REQ-011 All outputs SHALL be registered; o_led SHALL be 0 outside GRANT.
REQ-012 IDLE with i_req != 0 -> GRANT on the next edge; the winner is chosen round-robin, searching upward mod 4 from pointer ptr.
REQ-013 IDLE with i_req == 0 -> stay in IDLE.
REQ-014 Grant latency SHALL be 1 cycle: o_grant and o_led are valid on the edge after i_req is sampled high in IDLE.
REQ-015 In GRANT, o_led SHALL equal the granted source's i_pat, sampled every cycle, so pattern changes appear with 1 cycle latency.
REQ-016 On GRANT entry, the tick prescaler and slot counter SHALL restart; GRANT SHALL last exactly SLOT_TICKS*TICK_DIV cycles unless ended early.
REQ-017 GRANT SHALL end early, moving to GAP on the next edge, when the granted source's i_req is sampled low.
REQ-018 GAP SHALL last 1 cycle with o_led=0 and o_grant=0, set ptr to (granted index + 1) mod 4, then go to IDLE.
REQ-019 A persistent sole requester SHALL be re-granted after exactly 2 blank cycles (GAP and IDLE).
REQ-020 Requests from non-owners during GRANT SHALL be ignored; they are arbitrated only in IDLE.
REQ-021 The prescaler counter SHALL wrap at TICK_DIV-1 and the slot counter at SLOT_TICKS-1; both SHALL hold at 0 outside GRANT.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter, at minimum 1 bit.

Reset
REQ-023 Asserting i_rst SHALL immediately force: state IDLE, ptr 0, o_led 0, o_grant 0, o_busy 0, and all counters 0.
REQ-024 Reset asserted mid-GRANT SHALL abandon the slot with no GAP cycle.
REQ-025 After release, arbitration SHALL restart from source 0.
REQ-026 Deassertion of i_rst is synchronous to i_clk; i_req SHALL be ignored while i_rst is high.

Structure
REQ-027 Package led_arb_pkg SHALL hold the state enum type (IDLE/GRANT/GAP), NUM_REQ=4 and LED_W=8.
REQ-028 The tick generator SHALL be a sub-module, tick_prescaler, with clock, reset, enable and parameter DIV, outputting a 1-cycle tick pulse.
REQ-029 Round-robin selection SHALL be a combinational function in led_arbiter and SHALL NOT be a separate module.

Verification (bench overrides TICK_DIV=4, SLOT_TICKS=2, giving an 8-cycle slot; 20 ns clock)
REQ-030 i_rst=1 with i_req=4'b1111 -> o_led=8'h00, o_grant=4'b0000, o_busy=0 for the whole reset.
REQ-031 i_req=4'b0001, i_pat0=8'hA5 -> 1 cycle later o_grant=0001 and o_led=A5 for 8 cycles, then 2 cycles of 00, then re-grant.
REQ-032 i_req=4'b1111, distinct patterns -> o_grant sequence 0001,0010,0100,1000,0001, each held 8 cycles and separated by 2 blank cycles.
REQ-033 Granted source drops i_req at cycle 3 of its slot -> GAP on the next edge, o_led=00; the next requester is granted 2 cycles later.
REQ-034 i_rst pulsed at cycle 4 of source 2's slot, i_req=4'b1111 -> outputs clear immediately; after release the first grant is 0001.
REQ-035 Source 3 granted while i_req=4'b1010 -> after the slot, the next grant is 0010 (ptr wrapped to 0, then source 1 found).
